// File: rtl/wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wr_ptr_ctrl
// Brief   : Async FIFO write-domain pointer control with status and overflow.
// Revision: 1.0 - initial release
// ============================================================================
module wr_ptr_ctrl #(
    parameter int PTR_WIDTH    = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr,
    input  logic                 ovf_clr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 wclken,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH:0] c_afull_thresh = (PTR_WIDTH+1)'(AFULL_THRESH);

    logic [PTR_WIDTH:0] r_rptr_sync [SYNC_STAGES];
    logic [PTR_WIDTH:0] w_g_rptr_sync;
    logic [PTR_WIDTH:0] w_b_rptr_sync;
    logic [PTR_WIDTH:0] w_b_wptr_next;
    logic [PTR_WIDTH:0] w_g_wptr_next;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_full_next;
    logic               w_afull_next;

    // Read Gray pointer crosses into wclk through a plain flop chain
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        if (i == 0) begin : g_first
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) r_rptr_sync[i] <= '0;
                else         r_rptr_sync[i] <= g_rptr;
            end
        end else begin : g_rest
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) r_rptr_sync[i] <= '0;
                else         r_rptr_sync[i] <= r_rptr_sync[i-1];
            end
        end
    end

    assign w_g_rptr_sync = r_rptr_sync[SYNC_STAGES-1];

    always_comb begin
        w_b_rptr_sync = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            w_b_rptr_sync[i] = ^(w_g_rptr_sync >> i);
        end
    end

    assign wclken        = w_en & ~full;
    assign w_b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, wclken};
    assign w_g_wptr_next = w_b_wptr_next ^ (w_b_wptr_next >> 1);
    // Full when the write pointer is exactly one lap (MSB and MSB-1 of Gray inverted) ahead
    assign w_full_next   = (w_g_wptr_next == {~w_g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                               w_g_rptr_sync[PTR_WIDTH-2:0]});
    assign w_level_next  = w_b_wptr_next - w_b_rptr_sync;
    assign w_afull_next  = (w_level_next >= c_afull_thresh);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= w_b_wptr_next;
            g_wptr      <= w_g_wptr_next;
            full        <= w_full_next;
            almost_full <= w_afull_next;
            wr_level    <= w_level_next;
            if (w_en && full)  overflow <= 1'b1;
            else if (ovf_clr)  overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_wr_ptr_ctrl
// Brief   : Scoreboard bench for wr_ptr_ctrl (PTR_WIDTH=3, SYNC_STAGES=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_wr_ptr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       w_en;
    logic [3:0] g_rptr;
    logic       ovf_clr;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       wclken;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_b, m_s0, m_s1;
    logic       m_full, m_ovf;

    always #5 wclk = ~wclk;

    wr_ptr_ctrl #(
        .PTR_WIDTH    (3),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (6)
    ) u_dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .w_en        (w_en),
        .g_rptr      (g_rptr),
        .ovf_clr     (ovf_clr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .wclken      (wclken),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_b"},    32'(b_wptr),      32'd0);
        chk({tag, "_g"},    32'(g_wptr),      32'd0);
        chk({tag, "_full"}, 32'(full),        32'd0);
        chk({tag, "_af"},   32'(almost_full), 32'd0);
        chk({tag, "_lvl"},  32'(wr_level),    32'd0);
        chk({tag, "_ovf"},  32'(overflow),    32'd0);
    endtask

    task automatic model_reset();
        m_b = '0; m_s0 = '0; m_s1 = '0; m_full = 1'b0; m_ovf = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle at negedge, predict, then compare after the posedge
    task automatic cycle(input logic we, input logic [3:0] gr, input logic clr);
        exp_t       e;
        exp_t       got;
        logic       acc;
        logic [3:0] nb;
        @(negedge wclk);
        w_en = we; g_rptr = gr; ovf_clr = clr;
        #1;
        chk("wclken", 32'(wclken), 32'(we & ~m_full));
        acc    = we & ~m_full;
        nb     = m_b + 4'(acc);
        e.b    = nb;
        e.g    = bin2gray(nb);
        e.lvl  = nb - gray2bin(m_s1);
        e.full = (e.lvl == 4'd8);
        e.af   = (e.lvl >= 4'd6);
        e.ovf  = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_b = nb; m_full = e.full; m_ovf = e.ovf; m_s1 = m_s0; m_s0 = gr;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        got = sb.pop_front();
        chk("sb_b_wptr",   32'(b_wptr),      32'(got.b));
        chk("sb_g_wptr",   32'(g_wptr),      32'(got.g));
        chk("sb_wr_level", 32'(wr_level),    32'(got.lvl));
        chk("sb_full",     32'(full),        32'(got.full));
        chk("sb_afull",    32'(almost_full), 32'(got.af));
        chk("sb_overflow", 32'(overflow),    32'(got.ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rd;
        logic [3:0] prev_b;
        logic [3:0] prev_g;
        logic       saw_wrap;

        wrst_n = 1'b0; w_en = 1'b0; g_rptr = '0; ovf_clr = 1'b0;
        model_reset();

        // Reset held with random writes
        repeat (4) begin
            @(negedge wclk);
            w_en = 1'($urandom_range(0, 1));
            #1;
            chk_zero("rst_hold");
        end
        @(negedge wclk);
        w_en = 1'b0; wrst_n = 1'b1;
        cycle(1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0);
        chk_zero("rst_release");

        // Fill to full
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 4'd0, 1'b0);
            if (i == 5) chk("fill_af_5", 32'(almost_full), 32'd0);
            if (i == 6) chk("fill_af_6", 32'(almost_full), 32'd1);
            if (i == 7) chk("fill_full_7", 32'(full), 32'd0);
        end
        chk("fill_b",    32'(b_wptr),   32'h8);
        chk("fill_g",    32'(g_wptr),   32'hC);
        chk("fill_lvl",  32'(wr_level), 32'd8);
        chk("fill_full", 32'(full),     32'd1);

        // Overflow set / clear / set-wins
        cycle(1'b1, 4'd0, 1'b0);
        chk("ovf_b_held", 32'(b_wptr),   32'h8);
        chk("ovf_set",    32'(overflow), 32'd1);
        cycle(1'b0, 4'd0, 1'b1);
        chk("ovf_clr",    32'(overflow), 32'd0);
        cycle(1'b1, 4'd0, 1'b0);
        cycle(1'b1, 4'd0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);

        // Drain visibility through the synchronizer
        cycle(1'b0, 4'b0011, 1'b0);
        chk("drain_e1_full", 32'(full), 32'd1);
        cycle(1'b0, 4'b0011, 1'b0);
        chk("drain_e2_full", 32'(full), 32'd1);
        cycle(1'b0, 4'b0011, 1'b0);
        chk("drain_e3_full", 32'(full),        32'd0);
        chk("drain_e3_lvl",  32'(wr_level),    32'd6);
        chk("drain_e3_af",   32'(almost_full), 32'd1);

        // Empty, then wrap with reads trailing
        repeat (3) cycle(1'b0, bin2gray(4'd8), 1'b0);
        chk("pre_wrap_lvl", 32'(wr_level), 32'd0);
        saw_wrap = 1'b0;
        prev_b = b_wptr;
        prev_g = g_wptr;
        for (int i = 0; i < 20; i++) begin
            rd = (i == 0) ? 4'd8 : m_b - 4'd1;
            cycle(1'b1, bin2gray(rd), 1'b0);
            chk("wrap_no_full", 32'(full), 32'd0);
            chk("wrap_lvl_le4", 32'(wr_level <= 4'd4), 32'd1);
            if (prev_b == 4'd15) begin
                saw_wrap = 1'b1;
                chk("wrap_b_to_0",  32'(b_wptr), 32'd0);
                chk("wrap_g_prev",  32'(prev_g), 32'h8);
                chk("wrap_g_to_0",  32'(g_wptr), 32'd0);
            end
            prev_b = b_wptr;
            prev_g = g_wptr;
        end
        chk("wrap_seen", 32'(saw_wrap), 32'd1);

        // Bring to b_wptr=5 with overflow set, then asynchronous reset
        cycle(1'b1, bin2gray(4'd10), 1'b0);
        repeat (3) cycle(1'b0, bin2gray(4'd13), 1'b0);
        cycle(1'b0, bin2gray(4'd13), 1'b1);
        repeat (8) cycle(1'b1, bin2gray(4'd13), 1'b0);
        cycle(1'b1, bin2gray(4'd13), 1'b0);
        chk("mid_b5",  32'(b_wptr),   32'd5);
        chk("mid_ovf", 32'(overflow), 32'd1);
        #1;
        wrst_n = 1'b0;
        #1;
        chk_zero("mid_async");
        g_rptr = '0; w_en = 1'b0; ovf_clr = 1'b0;
        #1;
        wrst_n = 1'b1;
        model_reset();
        cycle(1'b1, 4'd0, 1'b0);
        chk("post_rst_b", 32'(b_wptr), 32'd1);
        chk("post_rst_g", 32'(g_wptr), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
